inc_button_conditioner: RTL
===========================

# inc_button_conditioner

- Conditions a raw push-button into a clean, single-cycle `inc` strobe for the 2-bit counter next-state logic (`Inc` input). Sits directly upstream of that logic.
- Synchronises the asynchronous pin, debounces it with a four-state FSM, and emits one `inc` pulse per accepted press.
- Optionally emits repeated pulses while the button is held.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000. Cycles the synchronised input must stay stable before a level change is accepted. Legal range is ≥2 and < 2^CNT_W.
- `REPEAT_DELAY`, default 25000000. Cycles from press acceptance to the first repeat pulse. Used only with the auto-repeat build.
- `REPEAT_PERIOD`, default 10000000. Cycles between subsequent repeat pulses. Used only with the auto-repeat build.
- `CNT_W`, default 26. Width of the debounce and repeat counters. All three cycle parameters must be < 2^CNT_W.

Ports:
- `clk`, input, 1 bit. Single clock; all state changes on its rising edge.
- `rst`, input, 1 bit. Reset, asynchronous and active-high.
- `btn_in`, input, 1 bit. Raw button pin. Asynchronous to `clk` and bouncy.
- `inc`, output, 1 bit. Registered one-cycle pulse; drives the counter's `Inc`.
- `btn_level`, output, 1 bit. Registered debounced button level.

## Operation

- **Synchroniser:** two flops `s1 <= btn_in`, `s2 <= s1`. Both reset to 0. Only `s2` feeds the FSM.
- **FSM states:** IDLE (level 0), CHECK_HI, HELD (level 1), CHECK_LO. Reset state is IDLE.
- **IDLE:**
  - `s2`=1 → CHECK_HI, with `cnt` cleared to 0.
- **CHECK_HI:**
  - `s2`=0 → IDLE. This is a bounce; no pulse is emitted.
  - Otherwise, if `cnt`==DEBOUNCE_CYCLES-1 → HELD. Assert `inc` for the next cycle and set `btn_level` to 1.
  - Otherwise `cnt`+1.
- **HELD:**
  - `s2`=0 → CHECK_LO, with `cnt` cleared to 0.
- **CHECK_LO:**
  - `s2`=1 → HELD. No pulse is emitted.
  - Otherwise, if `cnt`==DEBOUNCE_CYCLES-1 → IDLE and set `btn_level` to 0.
  - Otherwise `cnt`+1.
- **`inc` rules:**
  - `inc` is high for exactly one cycle per qualifying event.
  - It is never high for two consecutive cycles.
  - It is never asserted in IDLE, CHECK_HI or CHECK_LO, except on the cycle immediately after entering HELD from CHECK_HI.
- **`btn_level`** changes only on the CHECK_HI→HELD and CHECK_LO→IDLE transitions.
- **Counters** never wrap. `cnt` is compared for equality and cleared on every state entry.
- **Mid-operation reset:** asserting `rst` immediately clears `s1`, `s2`, state, `cnt`, the repeat counter, `inc` and `btn_level`. This holds even mid-pulse or mid-count.

## Timing

- **Reset values:** `inc`=0, `btn_level`=0.
- **Press latency:**
  - Edge 0 is the first edge sampling `btn_in`=1, with the pin held high afterwards.
  - CHECK_HI is entered at edge 2.
  - HELD is entered, and `inc` and `btn_level` rise, at edge 2+DEBOUNCE_CYCLES.
  - `inc` falls at the following edge.
- **Release latency:** symmetric. `btn_level` falls at edge 2+DEBOUNCE_CYCLES after the first low sample. No pulse on release.
- **Bounce rejection:** a glitch on `s2` shorter than DEBOUNCE_CYCLES cycles during CHECK_HI or CHECK_LO returns the FSM to its previous stable state. Outputs do not change.
- **No handshake:** the downstream counter samples `inc` every cycle.

## Configuration

- **Macro:** `INC_BTN_AUTOREPEAT_EN`.
- **Defined:**
  - In HELD, a repeat counter `rcnt` increments each cycle; it is cleared on CHECK_HI→HELD.
  - At `rcnt`==REPEAT_DELAY-1, pulse `inc`.
  - After that, pulse `inc` every REPEAT_PERIOD cycles for as long as the FSM stays in HELD.
  - `rcnt` holds its value in CHECK_LO and resumes on CHECK_LO→HELD.
  - `rcnt` is cleared on entry to IDLE.
  - A repeat pulse due on the same cycle as the HELD→CHECK_LO transition is suppressed.
- **Undefined:**
  - `rcnt` is not built.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.
  - Exactly one `inc` pulse is emitted per accepted press, regardless of hold time.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, CNT_W=8.

- **Clean press:** `btn_in` rises before edge 0 and is held for 30 cycles.
  - `inc`=1 only between edges 6 and 7.
  - `btn_level`=1 from edge 6.
  - Without the macro, no further pulses.
- **Bounce:** `btn_in` high for 3 cycles, low for 2, then high and held.
  - No pulse from the 3-cycle burst.
  - Exactly one pulse, 6 edges after the final rise.
- **Release bounce:** while in HELD, `btn_in` is low for 2 cycles, then high.
  - `btn_level` stays 1.
  - No `inc`.
- **Release:** `btn_in` low and held.
  - `btn_level` falls 6 edges after the first low sample.
  - `inc` stays 0.
- **Reset mid-count:** assert `rst` while in CHECK_HI with `cnt`=2.
  - `inc`=0 and `btn_level`=0 immediately.
  - After `rst` deasserts with `btn_in` held high, a pulse occurs 6 edges later.
- **Auto-repeat (macro defined):** hold `btn_in` for 40 cycles.
  - Pulses at edges 6, 16, 21, 26, 31, 36, ... while held.
  - All pulses are one cycle wide.

Source files
------------

// File: rtl/inc_button_conditioner.sv
// Purpose: synchronise, debounce and edge-detect a raw push-button into a one-cycle inc strobe.
// Latency: inc/btn_level rise 2+DEBOUNCE_CYCLES edges after the first high sample of btn_in.
// Backpressure: none; inc is a registered pulse sampled every cycle downstream.
// Optional feature: define INC_BTN_AUTOREPEAT_EN to emit repeat pulses while the button is held.
module inc_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic inc,
  output logic btn_level
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK_HI = 2'd1,
    HELD     = 2'd2,
    CHECK_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_inc;
  logic             w_inc_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             w_rep_pulse;

  assign inc       = r_inc;
  assign btn_level = r_level;

  // Two-flop synchroniser for the asynchronous pin; only r_s2 is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= btn_in;
      r_s2 <= r_s1;
    end
  end

  // State, debounce counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_inc   <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_inc   <= w_inc_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Next-state, counter and output decode; the counter is cleared on every state change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_inc_nxt   = 1'b0;
    w_level_nxt = r_level;
    case (r_state)
      IDLE: begin
        if (r_s2) begin
          w_state_nxt = CHECK_HI;
          w_cnt_nxt   = '0;
        end
      end
      CHECK_HI: begin
        if (!r_s2) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_inc_nxt   = 1'b1;
          w_level_nxt = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!r_s2) begin
          // A repeat pulse falling on this cycle is dropped.
          w_state_nxt = CHECK_LO;
          w_cnt_nxt   = '0;
        end else begin
          // Guard keeps inc from ever being high on two consecutive cycles.
          w_inc_nxt   = w_rep_pulse & ~r_inc;
        end
      end
      CHECK_LO: begin
        if (r_s2) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef INC_BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] r_rcnt;
  logic             r_rep_phase;

  // Phase 0 waits for the initial delay, phase 1 for each subsequent period.
  assign w_rep_pulse = r_rep_phase ? (r_rcnt == REP_PERIOD_LAST)
                                   : (r_rcnt == REP_DELAY_LAST);

  // Repeat counter: runs while staying in HELD, holds through CHECK_LO, restarts per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rcnt      <= '0;
      r_rep_phase <= 1'b0;
    end else if ((w_state_nxt == IDLE) || ((r_state == CHECK_HI) && (w_state_nxt == HELD))) begin
      r_rcnt      <= '0;
      r_rep_phase <= 1'b0;
    end else if ((r_state == HELD) && (w_state_nxt == HELD)) begin
      if (w_rep_pulse) begin
        r_rcnt      <= '0;
        r_rep_phase <= 1'b1;
      end else begin
        r_rcnt      <= r_rcnt + CNT_ONE;
      end
    end
  end
`else
  logic w_unused_rep;

  assign w_rep_pulse  = 1'b0;
  assign w_unused_rep = (REPEAT_DELAY != REPEAT_PERIOD);
`endif

endmodule
